// File: rtl/fp_simd_issuer.sv
// Command FIFO and issue sequencer driving the FP_SIMD enable/valid handshake.
// Optional WAIT-state abort: define FP_ISSUER_TIMEOUT_EN (limit set by TIMEOUT).
module fp_simd_issuer #(
   parameter int unsigned SIMD_WIDTH = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [2:0]                 s_opcode,
   input  logic [SIMD_WIDTH*22-1:0]   s_in1,
   input  logic [SIMD_WIDTH*22-1:0]   s_in2,
   input  logic [TAG_W-1:0]           s_tag,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [SIMD_WIDTH*22-1:0]   m_result,
   output logic [TAG_W-1:0]           m_tag,
   output logic                       m_err,
   output logic                       simd_en,
   output logic [SIMD_WIDTH*22-1:0]   simd_in1,
   output logic [SIMD_WIDTH*22-1:0]   simd_in2,
   output logic [2:0]                 simd_opcode,
   input  logic [SIMD_WIDTH*22-1:0]   simd_output,
   input  logic                       simd_valid,
   input  logic                       simd_busy,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_idle
);
   localparam int unsigned DW = SIMD_WIDTH * 22;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 3 + 2 * DW + TAG_W;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            simd_en_q, simd_en_d;
   logic [DW-1:0]   simd_in1_q, simd_in1_d, simd_in2_q, simd_in2_d;
   logic [2:0]      simd_opcode_q, simd_opcode_d;
   logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
   logic            m_valid_q, m_valid_d;
   logic [DW-1:0]   m_result_q, m_result_d;
   logic [TAG_W-1:0] m_tag_q, m_tag_d;
   logic            push, pop;
   logic [EW-1:0]   head;

`ifdef FP_ISSUER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic            m_err_q, m_err_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
`else
   logic            unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   // Next-state, FIFO bookkeeping and output register loads
   always_comb begin
      push          = s_valid && (count_q != CW'(DEPTH));
      pop           = (state_q == IDLE) && (count_q != '0) && !simd_busy && !m_valid_q;
      head          = mem_q[rd_ptr_q];
      state_d       = state_q;
      wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d       = count_q;
      simd_en_d     = simd_en_q;
      simd_in1_d    = simd_in1_q;
      simd_in2_d    = simd_in2_q;
      simd_opcode_d = simd_opcode_q;
      issue_tag_d   = issue_tag_q;
      m_valid_d     = m_valid_q;
      m_result_d    = m_result_q;
      m_tag_d       = m_tag_q;
`ifdef FP_ISSUER_TIMEOUT_EN
      m_err_d       = m_err_q;
      tmo_cnt_d     = tmo_cnt_q;
`endif
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      if (m_valid_q && m_ready) m_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = ISSUE;
               simd_en_d = 1'b1;
               {simd_opcode_d, simd_in1_d, simd_in2_d, issue_tag_d} = head;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef FP_ISSUER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         WAIT: begin
            if (simd_valid) begin
               state_d    = RELEASE;
               m_valid_d  = 1'b1;
               m_result_d = simd_output;
               m_tag_d    = issue_tag_q;
`ifdef FP_ISSUER_TIMEOUT_EN
               m_err_d    = 1'b0;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d    = RELEASE;
               m_valid_d  = 1'b1;
               m_result_d = '0;
               m_tag_d    = issue_tag_q;
               m_err_d    = 1'b1;
            end else begin
               tmo_cnt_d  = tmo_cnt_q + TW'(1);
`endif
            end
         end
         default: begin
            // One cycle with enable low lets FP_SIMD return to idle
            state_d   = IDLE;
            simd_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         simd_en_q     <= 1'b0;
         simd_in1_q    <= '0;
         simd_in2_q    <= '0;
         simd_opcode_q <= '0;
         issue_tag_q   <= '0;
         m_valid_q     <= 1'b0;
         m_result_q    <= '0;
         m_tag_q       <= '0;
`ifdef FP_ISSUER_TIMEOUT_EN
         m_err_q       <= 1'b0;
         tmo_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         simd_en_q     <= simd_en_d;
         simd_in1_q    <= simd_in1_d;
         simd_in2_q    <= simd_in2_d;
         simd_opcode_q <= simd_opcode_d;
         issue_tag_q   <= issue_tag_d;
         m_valid_q     <= m_valid_d;
         m_result_q    <= m_result_d;
         m_tag_q       <= m_tag_d;
`ifdef FP_ISSUER_TIMEOUT_EN
         m_err_q       <= m_err_d;
         tmo_cnt_q     <= tmo_cnt_d;
`endif
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_opcode, s_in1, s_in2, s_tag};
   end

   assign s_ready     = (count_q != CW'(DEPTH));
   assign o_count     = count_q;
   assign o_idle      = (count_q == '0) && (state_q == IDLE) && !m_valid_q;
   assign simd_en     = simd_en_q;
   assign simd_in1    = simd_in1_q;
   assign simd_in2    = simd_in2_q;
   assign simd_opcode = simd_opcode_q;
   assign m_valid     = m_valid_q;
   assign m_result    = m_result_q;
   assign m_tag       = m_tag_q;
`ifdef FP_ISSUER_TIMEOUT_EN
   assign m_err       = m_err_q;
`else
   assign m_err       = 1'b0;
`endif

endmodule
